// File: rtl/nanorv32_gpio.sv
// NanoRV32 GPIO peripheral: zero-wait-state register file, output/enable pins,
// synchronized inputs with per-pin edge-selectable sticky interrupt status.

module nanorv32_gpio_pin (
  input  logic clk_in,
  input  logic rst_n,
  input  logic pin,
  input  logic edge_sel,
  input  logic sts_clr,
  output logic data_in,
  output logic sts
);
  logic sync1, sync2, prev, ev;

  assign data_in = sync2;
  // Only sync2-vs-prev transitions count, so rewriting edge_sel never fires.
  assign ev = edge_sel ? (sync2 & ~prev) : (~sync2 & prev);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      sts   <= 1'b0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
      prev  <= sync2;
      sts   <= ev | (sts & ~sts_clr);
    end
  end
endmodule

module nanorv32_gpio #(
  parameter int GPIO_WIDTH               = 16,
  parameter int NANORV32_PERIPH_ADDR_MSB = 11,
  parameter int NANORV32_DATA_MSB        = 31
) (
  input  logic                              clk_in,
  input  logic                              rst_n,
  input  logic [NANORV32_PERIPH_ADDR_MSB:0] bus_gpio_addr,
  input  logic [3:0]                        bus_gpio_bytesel,
  input  logic [NANORV32_DATA_MSB:0]        bus_gpio_din,
  input  logic                              bus_gpio_en,
  output logic [NANORV32_DATA_MSB:0]        gpio_bus_dout,
  output logic                              gpio_bus_ready_nxt,
  input  logic [GPIO_WIDTH-1:0]             gpio_in,
  output logic [GPIO_WIDTH-1:0]             gpio_out,
  output logic [GPIO_WIDTH-1:0]             gpio_oe,
  output logic                              gpio_irq
);
  localparam logic [2:0] R_DOUT = 3'd0, R_OE = 3'd1, R_DIN = 3'd2, R_IEN = 3'd3,
                         R_ISTS = 3'd4, R_IEDG = 3'd5, R_SET = 3'd6, R_CLR = 3'd7;

  logic [GPIO_WIDTH-1:0] data_out, oe, irq_en, irq_edge, data_in, irq_sts, sts_clr;
  logic [GPIO_WIDTH-1:0] wmask, wdat;
  logic [2:0]            sel;
  logic                  addr_ok, wr, rd;
  logic [31:0]           rd_val;
  logic                  sink_unused;

  // Bits beyond GPIO_WIDTH on din/bytesel are legitimately ignored.
  assign sink_unused = ^{bus_gpio_din, bus_gpio_bytesel};

  assign sel     = bus_gpio_addr[4:2];
  assign addr_ok = (bus_gpio_addr[1:0] == 2'b00) &&
                   (bus_gpio_addr[NANORV32_PERIPH_ADDR_MSB:5] == '0);
  assign wr      = bus_gpio_en && (bus_gpio_bytesel != 4'b0000) && addr_ok;
  assign rd      = bus_gpio_en && (bus_gpio_bytesel == 4'b0000) && addr_ok;

  always_comb begin
    wmask = '0;
    for (int i = 0; i < GPIO_WIDTH; i++) wmask[i] = bus_gpio_bytesel[i/8];
  end
  assign wdat    = bus_gpio_din[GPIO_WIDTH-1:0] & wmask;
  assign sts_clr = (wr && sel == R_ISTS) ? wdat : '0;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
      oe       <= '0;
      irq_en   <= '0;
      irq_edge <= '0;
    end else if (wr) begin
      case (sel)
        R_DOUT:  data_out <= (data_out & ~wmask) | wdat;
        R_OE:    oe       <= (oe & ~wmask) | wdat;
        R_IEN:   irq_en   <= (irq_en & ~wmask) | wdat;
        R_IEDG:  irq_edge <= (irq_edge & ~wmask) | wdat;
        R_SET:   data_out <= data_out | wdat;
        R_CLR:   data_out <= data_out & ~wdat;
        default: ;
      endcase
    end
  end

  nanorv32_gpio_pin u_pin [GPIO_WIDTH-1:0] (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .pin      (gpio_in),
    .edge_sel (irq_edge),
    .sts_clr  (sts_clr),
    .data_in  (data_in),
    .sts      (irq_sts)
  );

  always_comb begin
    rd_val = '0;
    case (sel)
      R_DOUT:  rd_val[GPIO_WIDTH-1:0] = data_out;
      R_OE:    rd_val[GPIO_WIDTH-1:0] = oe;
      R_DIN:   rd_val[GPIO_WIDTH-1:0] = data_in;
      R_IEN:   rd_val[GPIO_WIDTH-1:0] = irq_en;
      R_ISTS:  rd_val[GPIO_WIDTH-1:0] = irq_sts;
      R_IEDG:  rd_val[GPIO_WIDTH-1:0] = irq_edge;
      default: rd_val = '0;
    endcase
  end

  assign gpio_bus_dout      = rd ? rd_val : '0;
  assign gpio_bus_ready_nxt = 1'b1;
  assign gpio_out           = data_out;
  assign gpio_oe            = oe;
  assign gpio_irq           = |(irq_sts & irq_en);
endmodule
